// File: rtl/sharpen_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sharpen_stream_ctrl
// Purpose  : Frame sequencer for the sharpening datapath.
//            - Accepts a raster pixel stream (valid/ready).
//            - Advances or stalls the fixed-latency datapath.
//            - Tracks in-flight pixels with a valid shift register.
//            - Clamps the signed datapath sum to 8 bits and presents it
//              downstream (valid/ready).
//            - Pulses frame_done once the last pixel has left downstream.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-low reset
//            start      - begin a frame (only honoured in IDLE)
//            in_valid   - upstream pixel valid
//            in_ready   - upstream pixel accepted when in_valid && in_ready
//            dp_stall   - hold datapath registers
//            dp_sum     - signed sum from the addition stage
//            out_valid  - out_pix valid
//            out_ready  - downstream accepts when out_valid && out_ready
//            out_pix    - clamped 8-bit result
//            row / col  - coordinates of the next pixel to accept
//            busy       - high in FILL, RUN and DRAIN
//            frame_done - one-cycle pulse at end of frame
// Revision : 1.0 - initial release
// ============================================================================
module sharpen_stream_ctrl #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int DP_LAT  = 2,
    parameter int SUM_W   = 21,
    parameter int COORD_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    dp_stall,
    input  logic signed [SUM_W-1:0] dp_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_pix,
    output logic [COORD_W-1:0]      row,
    output logic [COORD_W-1:0]      col,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int                  c_FILL_W    = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(DP_LAT - 1);
    localparam logic [COORD_W-1:0]  c_COL_LAST  = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0]  c_ROW_LAST  = COORD_W'(HEIGHT - 1);
    localparam logic signed [SUM_W-1:0] c_PIX_MAX = SUM_W'(255);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DP_LAT-1:0]   r_vsr;
    logic [c_FILL_W-1:0] r_fill_cnt;
    logic                r_last_taken;

    logic                w_active;
    logic                w_adv;
    logic                w_accept;
    logic                w_accept_last;
    logic                w_start_frame;
    logic [7:0]          w_clamped;

    // ------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_active      = 1'b0;
        w_adv         = 1'b0;
        in_ready      = 1'b0;
        w_accept      = 1'b0;
        w_accept_last = 1'b0;
        w_start_frame = 1'b0;
        dp_stall      = 1'b1;
        busy          = 1'b0;
        frame_done    = 1'b0;

        w_active = (r_state == S_FILL) || (r_state == S_RUN) || (r_state == S_DRAIN);
        // The pipeline may only move when the output register is free or
        // is being emptied this very cycle.
        w_adv    = w_active && (!out_valid || out_ready);
        in_ready = w_adv && ((r_state == S_FILL) || (r_state == S_RUN)) && !r_last_taken;
        w_accept = in_valid && in_ready;
        w_accept_last = w_accept && (row == c_ROW_LAST) && (col == c_COL_LAST);
        dp_stall = !w_adv;
        busy     = w_active;
        frame_done = (r_state == S_DONE);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_FILL;
                    w_start_frame = 1'b1;
                end
            end
            S_FILL: begin
                // Leave FILL once DP_LAT advancing cycles have primed the
                // pipeline; a tiny frame may already be fully taken here,
                // in which case RUN hands straight over to DRAIN.
                if (w_adv && (r_fill_cnt == c_FILL_LAST)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_adv && (w_accept_last || r_last_taken)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_vsr == '0) && (!out_valid || out_ready)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturate the signed sum into the 0..255 pixel range
    // ------------------------------------------------------------------
    always_comb begin
        w_clamped = dp_sum[7:0];
        if (dp_sum[SUM_W-1]) begin
            w_clamped = 8'h00;
        end else if (dp_sum > c_PIX_MAX) begin
            w_clamped = 8'hFF;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fill counter, in-flight tracking and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill_cnt <= '0;
            r_vsr      <= '0;
            out_valid  <= 1'b0;
            out_pix    <= 8'h00;
        end else begin
            if (w_start_frame) begin
                r_fill_cnt <= '0;
            end else if (w_adv && (r_state == S_FILL)) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end

            if (w_adv) begin
                // Shift in the accept flag; a non-accepting advance is a bubble.
                r_vsr <= (r_vsr << 1) | DP_LAT'(w_accept);
                if (r_vsr[DP_LAT-1]) begin
                    out_pix   <= w_clamped;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Raster coordinates of the next pixel to accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row          <= '0;
            col          <= '0;
            r_last_taken <= 1'b0;
        end else if (w_start_frame) begin
            row          <= '0;
            col          <= '0;
            r_last_taken <= 1'b0;
        end else if (w_accept) begin
            if (col == c_COL_LAST) begin
                if (row == c_ROW_LAST) begin
                    // Final pixel of the frame: coordinates freeze here.
                    r_last_taken <= 1'b1;
                end else begin
                    col <= '0;
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sharpen_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sharpen_stream_ctrl
// Purpose  : Self-checking bench for sharpen_stream_ctrl (4x2 frame,
//            DP_LAT=2). Includes a two-register datapath stand-in that
//            advances whenever dp_stall is low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sharpen_stream_ctrl;

    localparam int WIDTH   = 4;
    localparam int HEIGHT  = 2;
    localparam int DP_LAT  = 2;
    localparam int SUM_W   = 21;
    localparam int COORD_W = 10;
    localparam int NPIX    = WIDTH * HEIGHT;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic                    dp_stall;
    logic signed [SUM_W-1:0] dp_sum;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_pix;
    logic [COORD_W-1:0]      row;
    logic [COORD_W-1:0]      col;
    logic                    busy;
    logic                    frame_done;

    logic signed [SUM_W-1:0] in_data;
    logic signed [SUM_W-1:0] dp0;
    logic signed [SUM_W-1:0] dp1;

    int n_checks;
    int n_fail;
    int acc_cnt;
    int out_cnt;
    int fd_cnt;
    int fd_base;
    int stall_left;
    bit stalled;
    bit track;
    bit sb_on;
    bit hist_on;
    logic [2:0] hist;
    logic ordy;

    sharpen_stream_ctrl #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .DP_LAT (DP_LAT),
        .SUM_W  (SUM_W),
        .COORD_W(COORD_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dp_stall  (dp_stall),
        .dp_sum    (dp_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .row       (row),
        .col       (col),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the convolution + addition stages: DP_LAT registers.
    always @(posedge clk) begin
        if (!dp_stall) begin
            dp0 <= in_data;
            dp1 <= dp0;
        end
    end
    assign dp_sum = dp1;

    typedef struct {
        logic st;
        logic iv;
        logic ordy;
        int   pix;
        logic e_ir;
        logic e_stall;
        logic e_ov;
        int   e_pix;
        int   e_row;
        int   e_col;
        logic e_busy;
        logic e_fd;
    } vec_t;

    vec_t tbl[14];

    function automatic int clampf(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int pixval(input int k);
        return k * 50 - 30;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 ns later.
    task automatic cyc(input logic st, input logic iv, input logic o_rdy);
        @(negedge clk);
        start     = st;
        in_valid  = iv;
        out_ready = o_rdy;
        in_data   = SUM_W'(pixval(acc_cnt));
        #1;
        if (track) begin
            chk("row model", int'(row), (acc_cnt >= NPIX) ? HEIGHT - 1 : acc_cnt / WIDTH);
            chk("col model", int'(col), (acc_cnt >= NPIX) ? WIDTH - 1 : acc_cnt % WIDTH);
        end
        if (hist_on) begin
            chk("out_valid latency", int'(out_valid), int'(hist[2]));
        end
        if (sb_on && out_valid && out_ready) begin
            chk("scoreboard out_pix", int'(out_pix),
                (out_cnt < NPIX) ? clampf(pixval(out_cnt)) : -1);
            out_cnt++;
        end
        if (frame_done) fd_cnt++;
        hist = {hist[1:0], in_valid && in_ready};
        if (in_valid && in_ready) acc_cnt++;
    endtask

    task automatic new_frame();
        track   = 1'b0;
        hist    = 3'b000;
        cyc(1'b1, 1'b0, 1'b1);
        acc_cnt = 0;
        out_cnt = 0;
        fd_base = fd_cnt;
        track   = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        acc_cnt = 0; out_cnt = 0; fd_cnt = 0; fd_base = 0;
        track = 1'b0; sb_on = 1'b0; hist_on = 1'b0; hist = 3'b000;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        reset = 1'b0;

        //                st iv or  pix   ir stl ov pix  row col busy fd
        tbl[0]  = '{1'b1,1'b1,1'b1,   0, 1'b0,1'b1,1'b0,  0, 0,0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b1,  -5, 1'b1,1'b0,1'b0,  0, 0,0,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b1, 300, 1'b1,1'b0,1'b0,  0, 0,1,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b1, 128, 1'b1,1'b0,1'b0,  0, 0,2,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b1,   7, 1'b1,1'b0,1'b1,  0, 0,3,1'b1,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b1,  -1, 1'b1,1'b0,1'b1,255, 1,0,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b1, 256, 1'b1,1'b0,1'b1,128, 1,1,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b1,  42, 1'b1,1'b0,1'b1,  7, 1,2,1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b1, 100, 1'b1,1'b0,1'b1,  0, 1,3,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b1,   0, 1'b0,1'b0,1'b1,255, 1,3,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b1,1'b1,   0, 1'b0,1'b0,1'b1, 42, 1,3,1'b1,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b1,   0, 1'b0,1'b0,1'b1,100, 1,3,1'b1,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b1,   0, 1'b0,1'b1,1'b0,100, 1,3,1'b0,1'b1};
        tbl[13] = '{1'b0,1'b1,1'b1,   0, 1'b0,1'b1,1'b0,100, 1,3,1'b0,1'b0};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset dp_stall", int'(dp_stall), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- full frame, clamp, start handling ----------------
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start     = tbl[i].st;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            in_data   = SUM_W'(tbl[i].pix);
            #1;
            chk($sformatf("vec%0d in_ready", i),   int'(in_ready),   int'(tbl[i].e_ir));
            chk($sformatf("vec%0d dp_stall", i),   int'(dp_stall),   int'(tbl[i].e_stall));
            chk($sformatf("vec%0d out_valid", i),  int'(out_valid),  int'(tbl[i].e_ov));
            chk($sformatf("vec%0d out_pix", i),    int'(out_pix),    tbl[i].e_pix);
            chk($sformatf("vec%0d row", i),        int'(row),        tbl[i].e_row);
            chk($sformatf("vec%0d col", i),        int'(col),        tbl[i].e_col);
            chk($sformatf("vec%0d busy", i),       int'(busy),       int'(tbl[i].e_busy));
            chk($sformatf("vec%0d frame_done", i), int'(frame_done), int'(tbl[i].e_fd));
        end

        // ---------------- downstream stall for 5 cycles ----------------
        sb_on = 1'b1;
        new_frame();
        stalled = 1'b0;
        stall_left = 0;
        for (int k = 0; k < 60 && fd_cnt == fd_base; k++) begin
            if (!stalled && out_cnt == 3) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            ordy = (stall_left == 0);
            cyc(1'b0, 1'b1, ordy);
            if (stall_left > 0) begin
                chk("stall dp_stall", int'(dp_stall), 1);
                chk("stall in_ready", int'(in_ready), 0);
                chk("stall out_valid", int'(out_valid), 1);
                chk("stall out_pix held", int'(out_pix), clampf(pixval(out_cnt)));
                stall_left--;
            end
        end
        chk("stall window reached", int'(stalled), 1);
        chk("stall frame_done count", fd_cnt - fd_base, 1);
        chk("stall outputs", out_cnt, NPIX);
        chk("stall accepts", acc_cnt, NPIX);

        // ---------------- in_valid toggling 1,0,1,0 ----------------
        new_frame();
        hist_on = 1'b1;
        for (int k = 0; k < 60 && fd_cnt == fd_base; k++) begin
            cyc(1'b0, (k % 2) == 0, 1'b1);
        end
        hist_on = 1'b0;
        chk("toggle frame_done count", fd_cnt - fd_base, 1);
        chk("toggle outputs", out_cnt, NPIX);
        chk("toggle accepts", acc_cnt, NPIX);

        // ---------------- reset mid-RUN ----------------
        sb_on = 1'b0;
        new_frame();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b1);
        track = 1'b0;
        chk("pre-reset out_valid", int'(out_valid), 1);
        chk("pre-reset busy", int'(busy), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid reset out_valid", int'(out_valid), 0);
        chk("mid reset in_ready", int'(in_ready), 0);
        chk("mid reset dp_stall", int'(dp_stall), 1);
        chk("mid reset row", int'(row), 0);
        chk("mid reset col", int'(col), 0);
        chk("mid reset busy", int'(busy), 0);
        @(negedge clk);
        reset   = 1'b1;
        fd_base = fd_cnt;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            if (k == 10) begin
                chk("post reset idle busy", int'(busy), 0);
                chk("post reset idle in_ready", int'(in_ready), 0);
            end
        end
        chk("no frame_done after abort", fd_cnt - fd_base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
